fetch_ctrl: RTL

Sequencing controller for the instruction-fetch stage. It owns the program counter, issues requests to the instruction memory using a req/ready handshake, and applies stalls from hazard detection. It also handles branch redirects, including redirects that arrive while a memory access is in flight, and halts fetch on ebreak/ecall or a misaligned target. It sits between the hazard/branch logic in ID/EX and the imem_if interface.

---
 rtl/fetch_ctrl_pkg.sv | 8 +
 rtl/fetch_ctrl_if.sv | 8 +
 rtl/fetch_perf_cnt.sv | 19 +
 rtl/fetch_ctrl.sv | 81 ++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths, reset PC, PC increment and fetch FSM state encoding
package fetch_ctrl_pkg;
  localparam int NB_ADDR = 32;
  localparam int NB_WORD = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int PC_INC = 4;
  typedef enum logic [1:0] {BOOT, FETCH, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory request/ready handshake between fetch control and imem
interface fetch_ctrl_if #(parameter int NB_ADDR = 32);
  logic req;
  logic [NB_ADDR-1:0] addr;
  logic ready;
  modport master(output req, output addr, input ready);
  modport slave(input req, input addr, output ready);
endinterface

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: wrapping counters of accepted fetches and hazard-stalled fetch cycles
module fetch_perf_cnt (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);
  // count events; reset clears both
  always_ff @(posedge i_clock)
    if (i_reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      fetch_count <= fetch_count + {31'b0, fetch_inc};
      stall_count <= stall_count + {31'b0, stall_inc};
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, drives imem req/ready, applies stalls, redirects (incl. in-flight) and halts; FETCH_PERF_CNT_EN adds fetch/stall counters
module fetch_ctrl #(
  parameter int NB_ADDR = fetch_ctrl_pkg::NB_ADDR,
  parameter logic [NB_ADDR-1:0] RESET_PC = NB_ADDR'(fetch_ctrl_pkg::RESET_PC),
  parameter int BOOT_CYCLES = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_hazard_detected,
  input  logic               i_branch_taken,
  input  logic [NB_ADDR-1:0] i_branch_addr,
  input  logic               i_halt,
  fetch_ctrl_if.master       imem,
  output logic               o_if_valid,
  output logic               o_flush,
  output logic               o_misaligned,
  output logic               o_halted,
  output logic [31:0]        o_fetch_count,
  output logic [31:0]        o_stall_count
);
  import fetch_ctrl_pkg::*;
  localparam int BW = BOOT_CYCLES > 1 ? $clog2(BOOT_CYCLES) : 1;
  fetch_state_t state;
  logic [NB_ADDR-1:0] pc, br_addr, target;
  logic [BW-1:0] boot_cnt;
  logic br_pending, in_fetch, go, redirect, misaligned, take_br;
  assign in_fetch = state == FETCH && !i_reset;
  assign go = in_fetch & !i_halt;
  assign redirect = i_branch_taken | br_pending;
  assign target = i_branch_taken ? i_branch_addr : br_addr;
  assign misaligned = |target[1:0];
  assign take_br = go & redirect & !misaligned;
  assign imem.req = in_fetch;
  assign imem.addr = pc;
  assign o_flush = in_fetch & i_branch_taken;
  assign o_misaligned = go & redirect & misaligned;
  assign o_if_valid = go & !redirect & !i_hazard_detected & imem.ready;
  assign o_halted = state == HALTED && !i_reset;
  // boot delay, then PC sequencing by priority: halt, bad target, redirect, hazard hold, accept
  always_ff @(posedge i_clock)
    if (i_reset) begin
      state <= BOOT;
      pc <= RESET_PC;
      boot_cnt <= '0;
      br_pending <= 1'b0;
      br_addr <= '0;
    end else begin
      if (state == BOOT) begin
        boot_cnt <= boot_cnt + BW'(1);
        if (boot_cnt == BW'(BOOT_CYCLES - 1)) state <= FETCH;
      end
      if (in_fetch && (i_halt || o_misaligned)) begin
        state <= HALTED;
        br_pending <= 1'b0;
      end
      if (take_br && imem.ready) begin
        pc <= target;
        br_pending <= 1'b0;
      end
      if (take_br && !imem.ready) begin
        br_pending <= 1'b1;
        br_addr <= target;
      end
      if (o_if_valid) pc <= pc + NB_ADDR'(PC_INC);
    end
`ifdef FETCH_PERF_CNT_EN
  logic take_haz;
  assign take_haz = go & !redirect & i_hazard_detected;
  fetch_perf_cnt u_perf (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .fetch_inc(o_if_valid),
    .stall_inc(take_haz),
    .fetch_count(o_fetch_count),
    .stall_count(o_stall_count)
  );
`else
  assign o_fetch_count = '0;
  assign o_stall_count = '0;
`endif
endmodule
